decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed for RV32I.
REQ-002 The block SHALL expose these ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of all held instructions (branch/jump redirect).
- in_valid  input  1  fetch presents an instruction.
- pc_in  input  32  address of the next sequential instruction (instruction PC + 4), as produced by fetch.
- inst_in  input  32  raw instruction word.
- decode_ready  output  1  block can accept an instruction this cycle.
- out_valid  output  1  decoded bundle valid toward execute.
- ex_ready  input  1  execute accepts the bundle this cycle.
- out_pc  output  32  instruction PC.
- out_pc4  output  32  instruction PC + 4.
- rs1_addr  output  5  source register 1.
- rs2_addr  output  5  source register 2.
- rd_addr  output  5  destination register.
- rd_we  output  1  destination write enable.
- imm  output  32  sign-extended immediate.
- opcode  output  7  inst[6:0].
- funct3  output  3  inst[14:12].
- funct7_b5  output  1  inst[30].
- illegal  output  1  instruction not legal RV32I.

Function
REQ-003 An input transfer SHALL occur on a cycle with in_valid=1 and decode_ready=1; an output transfer SHALL occur on a cycle with out_valid=1 and ex_ready=1.
REQ-004 Decoding SHALL be combinational from inst_in/pc_in and captured into a 2-entry skid buffer with states EMPTY, ONE and TWO.
REQ-005 Transitions SHALL be:
- EMPTY+push -> ONE.
- ONE+push without pop -> TWO.
- ONE+pop without push -> EMPTY.
- ONE+push+pop -> ONE.
- TWO+pop -> ONE.
REQ-006 decode_ready SHALL be a registered signal, equal to 1 in EMPTY and ONE and 0 in TWO.
REQ-007 out_valid SHALL be 1 in ONE and TWO; the output SHALL always present the oldest entry, with latency exactly 1 cycle from push to out_valid in EMPTY.
REQ-008 The output bundle SHALL hold stable while out_valid=1 and ex_ready=0.
REQ-009 flush=1 SHALL force the state to EMPTY at the next edge, discard any same-cycle push, and dominate push and pop.
REQ-010 out_pc SHALL equal pc_in - 4 modulo 2^32 (pc_in=0 -> 0xFFFFFFFC), and out_pc4 SHALL equal pc_in.
REQ-011 imm SHALL be formed per instruction format:
- I-type (LOAD, OP-IMM, JALR): sign-extended inst[31:20].
- S: {inst[31:25], inst[11:7]}.
- B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- U: {inst[31:12], 12'b0}.
- J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- R-type, FENCE, SYSTEM: 0.
REQ-012 illegal SHALL be 1 when any of the following holds:
- inst[1:0] != 2'b11.
- opcode is not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM.
- BRANCH funct3 is 010 or 011.
- LOAD funct3 is 011, 110 or 111.
- STORE funct3 is above 010.
- JALR funct3 != 000.
REQ-013 rd_we SHALL be 0 for STORE, BRANCH, MISC-MEM, SYSTEM, illegal instructions, or rd_addr=0, and SHALL be 1 otherwise.
REQ-014 Illegal instructions SHALL propagate through the buffer like any other instruction.

Reset
REQ-015 While rst=1, the state SHALL be EMPTY, decode_ready=1, out_valid=0, and all other outputs and held entries 0.
REQ-016 Reset asserted mid-operation SHALL discard both entries immediately, with no transfer in that cycle.

Structure
REQ-017 Package decode_pkg SHALL hold:
- opcode localparams.
- the imm-format enum.
- the skid-state enum.
- the decoded-bundle packed struct (pc, pc4, rs1, rs2, rd, rd_we, imm, opcode, funct3, funct7_b5, illegal).
REQ-018 The buffer SHALL be one sub-module, skid_buffer, parameterised on a bundle width; field decode SHALL stay in decode.

Verification
REQ-019 Push inst 0x00500093 (addi x1,x0,5) with pc_in=0x104 -> next cycle out_valid=1, out_pc=0x100, rd_addr=1, imm=5, rd_we=1, illegal=0.
REQ-020 Push 0xFE000EE3 (beq, offset -4) -> imm=0xFFFFFFFC, rd_we=0; push 0x00002003 (lw x0) -> rd_we=0.
REQ-021 ex_ready=0 with three back-to-back pushes -> decode_ready falls after the second accept, the third is held by fetch, and all three emerge in order once ex_ready=1.
REQ-022 State TWO with flush=1 and in_valid=1 -> next cycle out_valid=0 and decode_ready=1, and no instruction emerges.
REQ-023 Push 0x00000000 and 0x0000307F -> illegal=1 for both, rd_we=0.
REQ-024 Assert rst while in ONE with ex_ready=0 -> out_valid drops asynchronously, and decode_ready=1 after release.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats, buffer states
// and the decoded bundle that travels from decode to execute.
package decode_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_TWO
  } skid_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic        illegal;
  } decode_bundle_t;

  localparam int unsigned BUNDLE_W = $bits(decode_bundle_t);

endpackage

// File: rtl/decode_skid_buffer.sv
// Two-entry skid buffer: head always holds the oldest entry, tail absorbs
// one push while the consumer stalls; ready and valid are registered.
module skid_buffer
  import decode_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] head_q, tail_q;
  logic             push, pop;
  logic             load_head, load_tail, head_from_tail;

  assign push     = push_valid & push_ready & ~flush;
  assign pop      = pop_valid & pop_ready;
  assign pop_data = head_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SKID_EMPTY;
      push_ready <= 1'b1;
      pop_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      push_ready <= (state_d != SKID_TWO);
      pop_valid  <= (state_d != SKID_EMPTY);
    end
  end

  // Next state and entry-load controls; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    load_head      = 1'b0;
    load_tail      = 1'b0;
    head_from_tail = 1'b0;
    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (push) begin
            state_d   = SKID_ONE;
            load_head = 1'b1;
          end
        end
        SKID_ONE: begin
          if (push && !pop) begin
            state_d   = SKID_TWO;
            load_tail = 1'b1;
          end else if (!push && pop) begin
            state_d = SKID_EMPTY;
          end else if (push && pop) begin
            load_head = 1'b1;
          end
        end
        SKID_TWO: begin
          if (pop) begin
            state_d        = SKID_ONE;
            head_from_tail = 1'b1;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head)           head_q <= push_data;
      else if (head_from_tail) head_q <= tail_q;
      if (load_tail)           tail_q <= push_data;
    end
  end

endmodule

// File: rtl/decode.sv
// RV32I instruction decode: combinational field/immediate/legality decode
// captured into a two-entry skid buffer toward execute.
module decode
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  output logic        decode_ready,
  output logic        out_valid,
  input  logic        ex_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic        rd_we,
  output logic [31:0] imm,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7_b5,
  output logic        illegal
);

  decode_bundle_t     dec_c, held;
  imm_fmt_e           fmt_c;
  logic               legal_op_c, bad_f3_c, no_wb_c, illegal_c;
  logic [6:0]         op_c;
  logic [2:0]         f3_c;
  logic [BUNDLE_W-1:0] held_bits;

  assign op_c = inst_in[6:0];
  assign f3_c = inst_in[14:12];

  // Classify opcode: immediate format, funct3 legality, writeback suppression.
  always_comb begin
    fmt_c      = IMM_NONE;
    legal_op_c = 1'b1;
    bad_f3_c   = 1'b0;
    no_wb_c    = 1'b0;
    case (op_c)
      OPC_LUI, OPC_AUIPC: fmt_c = IMM_U;
      OPC_JAL:            fmt_c = IMM_J;
      OPC_JALR: begin
        fmt_c    = IMM_I;
        bad_f3_c = (f3_c != 3'b000);
      end
      OPC_BRANCH: begin
        fmt_c    = IMM_B;
        bad_f3_c = (f3_c == 3'b010) || (f3_c == 3'b011);
        no_wb_c  = 1'b1;
      end
      OPC_LOAD: begin
        fmt_c    = IMM_I;
        bad_f3_c = (f3_c == 3'b011) || (f3_c == 3'b110) || (f3_c == 3'b111);
      end
      OPC_STORE: begin
        fmt_c    = IMM_S;
        bad_f3_c = (f3_c > 3'b010);
        no_wb_c  = 1'b1;
      end
      OPC_OP_IMM:               fmt_c   = IMM_I;
      OPC_OP:                   fmt_c   = IMM_NONE;
      OPC_MISC_MEM, OPC_SYSTEM: no_wb_c = 1'b1;
      default:                  legal_op_c = 1'b0;
    endcase
  end

  assign illegal_c = (inst_in[1:0] != 2'b11) || !legal_op_c || bad_f3_c;

  always_comb begin
    dec_c           = '0;
    dec_c.pc        = pc_in - 32'd4;
    dec_c.pc4       = pc_in;
    dec_c.rs1       = inst_in[19:15];
    dec_c.rs2       = inst_in[24:20];
    dec_c.rd        = inst_in[11:7];
    dec_c.rd_we     = !no_wb_c && !illegal_c && (inst_in[11:7] != 5'd0);
    dec_c.opcode    = op_c;
    dec_c.funct3    = f3_c;
    dec_c.funct7_b5 = inst_in[30];
    dec_c.illegal   = illegal_c;
    case (fmt_c)
      IMM_I:   dec_c.imm = {{20{inst_in[31]}}, inst_in[31:20]};
      IMM_S:   dec_c.imm = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
      IMM_B:   dec_c.imm = {{19{inst_in[31]}}, inst_in[31], inst_in[7],
                            inst_in[30:25], inst_in[11:8], 1'b0};
      IMM_U:   dec_c.imm = {inst_in[31:12], 12'b0};
      IMM_J:   dec_c.imm = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12],
                            inst_in[20], inst_in[30:21], 1'b0};
      default: dec_c.imm = 32'd0;
    endcase
  end

  skid_buffer #(.WIDTH(BUNDLE_W)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (in_valid),
    .push_data  (dec_c),
    .push_ready (decode_ready),
    .pop_valid  (out_valid),
    .pop_ready  (ex_ready),
    .pop_data   (held_bits)
  );

  assign held      = held_bits;
  assign out_pc    = held.pc;
  assign out_pc4   = held.pc4;
  assign rs1_addr  = held.rs1;
  assign rs2_addr  = held.rs2;
  assign rd_addr   = held.rd;
  assign rd_we     = held.rd_we;
  assign imm       = held.imm;
  assign opcode    = held.opcode;
  assign funct3    = held.funct3;
  assign funct7_b5 = held.funct7_b5;
  assign illegal   = held.illegal;

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for decode: field decode, skid flow control,
// flush and asynchronous reset.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, ex_ready;
  logic [31:0] pc_in, inst_in;
  logic        decode_ready, out_valid, rd_we, funct7_b5, illegal;
  logic [31:0] out_pc, out_pc4, imm;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;

  int errors = 0;
  int checks = 0;

  decode dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .pc_in(pc_in), .inst_in(inst_in), .decode_ready(decode_ready),
    .out_valid(out_valid), .ex_ready(ex_ready), .out_pc(out_pc),
    .out_pc4(out_pc4), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .rd_we(rd_we), .imm(imm), .opcode(opcode),
    .funct3(funct3), .funct7_b5(funct7_b5), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single edge; with ex_ready=1 it leaves the
  // buffer again on the following edge.
  task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    pc_in    = pc;
    inst_in  = inst;
    tick();
    in_valid = 1'b0;
  endtask

  // Expected outputs for a single held instruction.
  typedef struct {
    string       tag;
    logic [31:0] pc_in;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        rd_we;
    logic        illegal;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b0;
    pc_in = '0; inst_in = '0;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ready",     32'(decode_ready), 32'd1);
    check("rst_pc",        out_pc, 32'd0);
    check("rst_imm",       imm, 32'd0);
    check("rst_illegal",   32'(illegal), 32'd0);
    rst = 1'b0;
    tick();

    // Single-instruction decode vectors (hand-computed).
    vecs.push_back('{"addi",     32'h104, 32'h00500093, 32'h100,      5'd1, 32'd5,          1'b1, 1'b0});
    vecs.push_back('{"beq",      32'h0,   32'hFE000EE3, 32'hFFFFFFFC, 5'd29, 32'hFFFFFFFC,  1'b0, 1'b0});
    vecs.push_back('{"lw_x0",    32'h108, 32'h00002003, 32'h104,      5'd0, 32'd0,          1'b0, 1'b0});
    vecs.push_back('{"zero",     32'h10C, 32'h00000000, 32'h108,      5'd0, 32'd0,          1'b0, 1'b1});
    vecs.push_back('{"op7f",     32'h110, 32'h0000307F, 32'h10C,      5'd0, 32'd0,          1'b0, 1'b1});
    vecs.push_back('{"lui",      32'h114, 32'h123450B7, 32'h110,      5'd1, 32'h12345000,   1'b1, 1'b0});
    vecs.push_back('{"sw",       32'h118, 32'h00112223, 32'h114,      5'd4, 32'd4,          1'b0, 1'b0});
    vecs.push_back('{"jal",      32'h11C, 32'h008000EF, 32'h118,      5'd1, 32'd8,          1'b1, 1'b0});
    vecs.push_back('{"jalr_f3",  32'h120, 32'h000010E7, 32'h11C,      5'd1, 32'd0,          1'b0, 1'b1});
    vecs.push_back('{"ld_f3_3",  32'h124, 32'h00003083, 32'h120,      5'd1, 32'd0,          1'b0, 1'b1});

    ex_ready = 1'b1;
    foreach (vecs[i]) begin
      push_one(vecs[i].pc_in, vecs[i].inst);
      check({vecs[i].tag, "_valid"},   32'(out_valid), 32'd1);
      check({vecs[i].tag, "_pc"},      out_pc, vecs[i].pc);
      check({vecs[i].tag, "_pc4"},     out_pc4, vecs[i].pc_in);
      check({vecs[i].tag, "_rd"},      32'(rd_addr), 32'(vecs[i].rd));
      check({vecs[i].tag, "_imm"},     imm, vecs[i].imm);
      check({vecs[i].tag, "_rd_we"},   32'(rd_we), 32'(vecs[i].rd_we));
      check({vecs[i].tag, "_illegal"}, 32'(illegal), 32'(vecs[i].illegal));
      check({vecs[i].tag, "_opcode"},  32'(opcode), 32'(vecs[i].inst[6:0]));
      tick();
      check({vecs[i].tag, "_drain"},   32'(out_valid), 32'd0);
    end

    // Back-pressure: three pushes with execute stalled.
    ex_ready = 1'b0;
    push_one(32'h204, 32'h00100093);
    check("bp_ready_one", 32'(decode_ready), 32'd1);
    push_one(32'h208, 32'h00200113);
    check("bp_ready_two", 32'(decode_ready), 32'd0);
    check("bp_head_a",    out_pc, 32'h200);
    in_valid = 1'b1; pc_in = 32'h20C; inst_in = 32'h00300193;
    tick();
    check("bp_hold_a",    out_pc, 32'h200);
    check("bp_hold_imm",  imm, 32'd1);
    ex_ready = 1'b1;
    tick();
    check("bp_head_b",    out_pc, 32'h204);
    check("bp_b_rd",      32'(rd_addr), 32'd2);
    check("bp_ready_b",   32'(decode_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_head_c",    out_pc, 32'h208);
    check("bp_c_imm",     imm, 32'd3);
    tick();
    check("bp_empty",     32'(out_valid), 32'd0);

    // Flush in TWO with a concurrent push attempt.
    ex_ready = 1'b0;
    push_one(32'h304, 32'h00100093);
    push_one(32'h308, 32'h00200113);
    check("fl_two_ready", 32'(decode_ready), 32'd0);
    flush = 1'b1; in_valid = 1'b1; pc_in = 32'h30C; inst_in = 32'h00300193;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid",     32'(out_valid), 32'd0);
    check("fl_ready",     32'(decode_ready), 32'd1);
    ex_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fl_nothing",  32'(out_valid), 32'd0);
    end

    // Flush in ONE drops a same-cycle push.
    ex_ready = 1'b0;
    push_one(32'h404, 32'h00100093);
    flush = 1'b1; in_valid = 1'b1; pc_in = 32'h408;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl1_valid",    32'(out_valid), 32'd0);

    // Asynchronous reset while holding one entry.
    push_one(32'h504, 32'h00500093);
    check("ar_valid_pre", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid_async", 32'(out_valid), 32'd0);
    check("ar_pc_async",    out_pc, 32'd0);
    #1 rst = 1'b0;
    tick();
    check("ar_ready_after", 32'(decode_ready), 32'd1);
    check("ar_valid_after", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
